l1_l2_arbiter: RTL

- Shares the single L2 cache port between the L1 instruction cache and the L1 data cache.
- Each L1 issues line-sized (128-bit, lc3b_mem_data) read or write transactions.
- The arbiter grants one requester at a time and alternates grants round-robin.
- It forwards the granted transaction to L2 and routes the L2 response back only to the granted requester.

---
 rtl/l1_l2_arbiter.sv | 77 +++++++
 1 files changed

// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter: round-robin sharing of one L2 port between the L1 I-cache and D-cache,
// with saturating per-requester wait counters.
module l1_l2_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_mem_read,
    input  logic [ADDR_WIDTH-1:0] i_mem_address,
    output logic [LINE_WIDTH-1:0] i_mem_rdata,
    output logic                  i_mem_resp,
    input  logic                  d_mem_read,
    input  logic                  d_mem_write,
    input  logic [ADDR_WIDTH-1:0] d_mem_address,
    input  logic [LINE_WIDTH-1:0] d_mem_wdata,
    output logic [LINE_WIDTH-1:0] d_mem_rdata,
    output logic                  d_mem_resp,
    output logic                  l2_read,
    output logic                  l2_write,
    output logic [ADDR_WIDTH-1:0] l2_address,
    output logic [LINE_WIDTH-1:0] l2_wdata,
    input  logic [LINE_WIDTH-1:0] l2_rdata,
    input  logic                  l2_resp,
    output logic [15:0]           i_wait_count,
    output logic [15:0]           d_wait_count
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
    state_t state;
    logic last_grant, write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic i_req, d_req, grant_i, grant_d, i_wait_inc, d_wait_inc;
    assign i_req = i_mem_read;
    assign d_req = d_mem_read | d_mem_write;
    // On a tie the side that did not win last time gets the port.
    assign grant_i = (state == IDLE) & i_req & (~d_req | last_grant);
    assign grant_d = (state == IDLE) & d_req & (~i_req | ~last_grant);
    assign i_wait_inc = i_req & ((state == SERVE_D) | grant_d);
    assign d_wait_inc = d_req & ((state == SERVE_I) | grant_i);
    assign l2_read = (state != IDLE) & ~write_q;
    assign l2_write = (state != IDLE) & write_q;
    assign l2_address = addr_q;
    assign l2_wdata = wdata_q;
    assign i_mem_resp = (state == SERVE_I) & l2_resp;
    assign d_mem_resp = (state == SERVE_D) & l2_resp;
    assign i_mem_rdata = (state == SERVE_I) ? l2_rdata : '0;
    assign d_mem_rdata = (state == SERVE_D) ? l2_rdata : '0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            last_grant <= 1'b1;
            addr_q <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            i_wait_count <= '0;
            d_wait_count <= '0;
        end else begin
            if (grant_i) begin
                state <= SERVE_I;
                addr_q <= i_mem_address;
                write_q <= 1'b0;
                last_grant <= 1'b0;
            end else if (grant_d) begin
                state <= SERVE_D;
                addr_q <= d_mem_address;
                wdata_q <= d_mem_wdata;
                write_q <= d_mem_write;
                last_grant <= 1'b1;
            end else if (state != IDLE && l2_resp) begin
                state <= IDLE;
            end
            if (i_wait_inc && i_wait_count != 16'hFFFF) i_wait_count <= i_wait_count + 16'd1;
            if (d_wait_inc && d_wait_count != 16'hFFFF) d_wait_count <= d_wait_count + 16'd1;
        end
    end
endmodule
